maze_generator: RTL and testbench

//  Writes the 16x16 path bitmap that the VGA maze renderer displays. Bit index = x + 16*y; 1 = open path.
//  On a start pulse, clears the bitmap and carves a perfect maze with the binary-tree algorithm, one cell per clock.

---
 rtl/maze_generator.sv | 164 ++++++++++++++++
 tb/tb_maze_generator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/maze_generator.sv
// maze_generator: carves a 16x16 path bitmap with the binary-tree algorithm,
// one cell per clock, and drives the start/finish tile coordinates.
// Optional feature macro: MAZE_LOOPS_EN (adds loops on some interior cells).
module maze_generator #(
    parameter int          GRID     = 16,
    parameter logic [15:0] DEF_SEED = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [15:0]            seed,
    input  logic [4:0]             maze_width,
    input  logic [4:0]             maze_height,
    output logic [GRID*GRID-1:0]   path_data,
    output logic [4:0]             start_x,
    output logic [4:0]             start_y,
    output logic [4:0]             finish_x,
    output logic [4:0]             finish_y,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {IDLE, CLEAR, CARVE} state_t;

    state_t      state;
    logic [4:0]  w_eff;
    logic [4:0]  h_eff;
    logic [4:0]  cell_x;
    logic [4:0]  cell_y;
    logic [15:0] lfsr;

    logic [4:0]  x_max;
    logic [4:0]  y_max;
    logic        at_xm;
    logic        at_row1;
    logic        carve_north;
    logic        carve_east;
    logic [4:0]  east_x;
    logic [4:0]  north_y;
    logic [7:0]  cell_idx;
    logic [7:0]  east_idx;
    logic [7:0]  north_idx;

    // Clamp a requested dimension to 3..15 and force it odd so the border is closed.
    function automatic logic [4:0] clamp_dim(input logic [4:0] v);
        logic [4:0] c;
        if (v < 5'd3)
            c = 5'd3;
        else if (v > 5'd15)
            c = 5'd15;
        else
            c = v;
        if (!c[0])
            c = c - 5'd1;
        return c;
    endfunction

    // 16-bit Galois LFSR step, right-shifting, taps 0xB400.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Carve decision for the current cell: forced on the top row and last column.
    always_comb begin
        x_max       = w_eff - 5'd2;
        y_max       = h_eff - 5'd2;
        at_xm       = (cell_x == x_max);
        at_row1     = (cell_y == 5'd1);
        carve_north = 1'b0;
        carve_east  = 1'b0;
        east_x      = cell_x + 5'd1;
        north_y     = cell_y - 5'd1;
        cell_idx    = {cell_y[3:0], cell_x[3:0]};
        east_idx    = {cell_y[3:0], east_x[3:0]};
        north_idx   = {north_y[3:0], cell_x[3:0]};
        if (at_row1 && at_xm) begin
            carve_north = 1'b0;
            carve_east  = 1'b0;
        end else if (at_row1) begin
            carve_east = 1'b1;
        end else if (at_xm) begin
            carve_north = 1'b1;
        end else begin
`ifdef MAZE_LOOPS_EN
            if (lfsr[3:0] == 4'h0) begin
                carve_north = 1'b1;
                carve_east  = 1'b1;
            end else if (lfsr[0])
                carve_east = 1'b1;
            else
                carve_north = 1'b1;
`else
            if (lfsr[0])
                carve_east = 1'b1;
            else
                carve_north = 1'b1;
`endif
        end
    end

    // Generation FSM: IDLE -> CLEAR -> CARVE (one cell per cycle) -> IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            path_data <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            start_x   <= 5'd1;
            start_y   <= 5'd1;
            finish_x  <= 5'd1;
            finish_y  <= 5'd1;
            lfsr      <= DEF_SEED;
            w_eff     <= 5'd3;
            h_eff     <= 5'd3;
            cell_x    <= 5'd1;
            cell_y    <= 5'd1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w_eff <= clamp_dim(maze_width);
                        h_eff <= clamp_dim(maze_height);
                        lfsr  <= (seed == 16'h0000) ? DEF_SEED : seed;
                        busy  <= 1'b1;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    path_data <= '0;
                    cell_x    <= 5'd1;
                    cell_y    <= 5'd1;
                    start_x   <= 5'd1;
                    start_y   <= y_max;
                    finish_x  <= x_max;
                    finish_y  <= 5'd1;
                    state     <= CARVE;
                end
                CARVE: begin
                    path_data[cell_idx] <= 1'b1;
                    if (carve_north)
                        path_data[north_idx] <= 1'b1;
                    if (carve_east)
                        path_data[east_idx] <= 1'b1;
                    lfsr <= lfsr_next(lfsr);
                    if (at_xm) begin
                        if (cell_y == y_max) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cell_x <= 5'd1;
                            cell_y <= cell_y + 5'd2;
                        end
                    end else begin
                        cell_x <= cell_x + 5'd2;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_generator.sv
// tb_maze_generator: directed self-checking bench for maze_generator.
module tb_maze_generator;

    logic         clk;
    logic         reset;
    logic         start;
    logic [15:0]  seed;
    logic [4:0]   maze_width;
    logic [4:0]   maze_height;
    logic [255:0] path_data;
    logic [4:0]   start_x;
    logic [4:0]   start_y;
    logic [4:0]   finish_x;
    logic [4:0]   finish_y;
    logic         busy;
    logic         done;

    int checks;
    int failures;
    int edges;
    int busy_cycles;
    int done_count;
    int done_edge;

    logic [255:0] exp_map;
    logic [255:0] saved_map;
    logic [19:0]  coords;

    maze_generator #(.GRID(16), .DEF_SEED(16'hACE1)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .seed        (seed),
        .maze_width  (maze_width),
        .maze_height (maze_height),
        .path_data   (path_data),
        .start_x     (start_x),
        .start_y     (start_y),
        .finish_x    (finish_x),
        .finish_y    (finish_y),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign coords = {start_x, start_y, finish_x, finish_y};

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bits that every binary-tree maze of size w x h must contain:
    // all cells, the whole top cell row, and the whole last cell column.
    function automatic logic [255:0] forced_mask(input int w, input int h);
        logic [255:0] m;
        m = '0;
        for (int y = 1; y <= h - 2; y += 2)
            for (int x = 1; x <= w - 2; x += 2)
                m[x + 16*y] = 1'b1;
        for (int x = 1; x <= w - 2; x++)
            m[x + 16] = 1'b1;
        for (int y = 1; y <= h - 2; y++)
            m[(w - 2) + 16*y] = 1'b1;
        return m;
    endfunction

    function automatic logic [255:0] region_mask(input int w, input int h);
        logic [255:0] m;
        m = '0;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                m[x + 16*y] = 1'b1;
        return m;
    endfunction

    // Drive one start request and watch until a few cycles past done.
    // edges counts clock edges after start is driven; edge 1 accepts it.
    task automatic run_maze(input logic [4:0] w, input logic [4:0] h,
                            input logic [15:0] s, input bit poke);
        maze_width  = w;
        maze_height = h;
        seed        = s;
        start       = 1'b1;
        edges       = 0;
        busy_cycles = 0;
        done_count  = 0;
        done_edge   = 0;
        while (edges < 400 && !(done_edge != 0 && edges >= done_edge + 3)) begin
            tick();
            edges++;
            if (edges == 1)
                start = 1'b0;
            if (poke && edges == 3) begin
                start       = 1'b1;
                maze_width  = 5'd15;
                maze_height = 5'd15;
                seed        = 16'h5555;
            end
            if (poke && edges == 4)
                start = 1'b0;
            if (busy)
                busy_cycles++;
            if (done) begin
                done_count++;
                if (done_edge == 0)
                    done_edge = edges;
            end
        end
        check_eq("done_seen", {255'd0, done_edge != 0}, 256'd1);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        start       = 1'b0;
        seed        = 16'h0000;
        maze_width  = 5'd3;
        maze_height = 5'd3;
        tick();
        tick();

        // Reset state
        check_eq("rst_path", path_data, 256'd0);
        check_eq("rst_busy", {255'd0, busy}, 256'd0);
        check_eq("rst_done", {255'd0, done}, 256'd0);
        check_eq("rst_coords", {236'd0, coords}, {236'd0, 5'd1, 5'd1, 5'd1, 5'd1});
        reset = 1'b0;
        tick();

        // T1: smallest maze, a single cell
        run_maze(5'd3, 5'd3, 16'h1234, 1'b0);
        exp_map = '0;
        exp_map[17] = 1'b1;
        check_eq("t1_path", path_data, exp_map);
        check_eq("t1_coords", {236'd0, coords}, {236'd0, 5'd1, 5'd1, 5'd1, 5'd1});
        check_eq("t1_busy_cycles", busy_cycles, 2);
        check_eq("t1_done_edge", done_edge, 3);
        check_eq("t1_done_count", done_count, 1);

        // T2: 5x5 with default seed; cell (1,3) sees LFSR 0x7138 -> north
        run_maze(5'd5, 5'd5, 16'hACE1, 1'b0);
        exp_map = '0;
        exp_map[17] = 1'b1; exp_map[18] = 1'b1; exp_map[19] = 1'b1;
        exp_map[33] = 1'b1; exp_map[35] = 1'b1; exp_map[49] = 1'b1; exp_map[51] = 1'b1;
        check_eq("t2_path_ace1", path_data, exp_map);
        check_eq("t2_coords", {236'd0, coords}, {236'd0, 5'd1, 5'd3, 5'd3, 5'd1});
        check_eq("t2_popcount", $countones(path_data), 7);

        // T2b: seed 4 -> LFSR 0x0001 at cell (1,3) -> east
        run_maze(5'd5, 5'd5, 16'h0004, 1'b0);
        exp_map = '0;
        exp_map[17] = 1'b1; exp_map[18] = 1'b1; exp_map[19] = 1'b1;
        exp_map[35] = 1'b1; exp_map[49] = 1'b1; exp_map[50] = 1'b1; exp_map[51] = 1'b1;
        check_eq("t2_path_seed4", path_data, exp_map);

        // T3: full-size maze, latency and determinism
        run_maze(5'd15, 5'd15, 16'h1234, 1'b0);
        check_eq("t3_done_edge", done_edge, 51);
        check_eq("t3_busy_cycles", busy_cycles, 50);
        check_eq("t3_popcount", $countones(path_data), 97);
        check_eq("t3_forced", path_data & forced_mask(15, 15), forced_mask(15, 15));
        check_eq("t3_outside", path_data & ~region_mask(15, 15), 256'd0);
        check_eq("t3_coords", {236'd0, coords}, {236'd0, 5'd1, 5'd13, 5'd13, 5'd1});
        saved_map = path_data;
        run_maze(5'd15, 5'd15, 16'h1234, 1'b0);
        check_eq("t3_repeat", path_data, saved_map);

        // T4: 6x20 is clamped to 5x15
        run_maze(5'd6, 5'd20, 16'hBEEF, 1'b0);
        check_eq("t4_coords", {236'd0, coords}, {236'd0, 5'd1, 5'd13, 5'd3, 5'd1});
        check_eq("t4_popcount", $countones(path_data), 27);
        check_eq("t4_forced", path_data & forced_mask(5, 15), forced_mask(5, 15));
        check_eq("t4_outside", path_data & ~region_mask(5, 15), 256'd0);
        check_eq("t4_done_edge", done_edge, 16);

        // T5: reset in the middle of carving
        maze_width  = 5'd15;
        maze_height = 5'd15;
        seed        = 16'h1234;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++)
            tick();
        check_eq("t5_busy_before", {255'd0, busy}, 256'd1);
        reset = 1'b1;
        tick();
        check_eq("t5_path", path_data, 256'd0);
        check_eq("t5_busy", {255'd0, busy}, 256'd0);
        check_eq("t5_done", {255'd0, done}, 256'd0);
        check_eq("t5_coords", {236'd0, coords}, {236'd0, 5'd1, 5'd1, 5'd1, 5'd1});
        reset = 1'b0;
        tick();
        run_maze(5'd5, 5'd5, 16'h0004, 1'b0);
        exp_map = '0;
        exp_map[17] = 1'b1; exp_map[18] = 1'b1; exp_map[19] = 1'b1;
        exp_map[35] = 1'b1; exp_map[49] = 1'b1; exp_map[50] = 1'b1; exp_map[51] = 1'b1;
        check_eq("t5_after_reset", path_data, exp_map);
        check_eq("t5_done_count", done_count, 1);

        // T6: seed 0 behaves as 0xACE1; start and size changes while busy are ignored
        run_maze(5'd5, 5'd5, 16'h0000, 1'b1);
        exp_map = '0;
        exp_map[17] = 1'b1; exp_map[18] = 1'b1; exp_map[19] = 1'b1;
        exp_map[33] = 1'b1; exp_map[35] = 1'b1; exp_map[49] = 1'b1; exp_map[51] = 1'b1;
        check_eq("t6_path_seed0", path_data, exp_map);
        check_eq("t6_done_count", done_count, 1);
        check_eq("t6_busy_cycles", busy_cycles, 5);
        check_eq("t6_idle_after", {255'd0, busy}, 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
